// File: rtl/watch_cu_pkg.sv
// Shared definitions for the watch control unit: FSM encoding, edit-field
// one-hot constants and the debug view of the block.
package watch_cu_pkg;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_EDIT_SEC  = 2'd1,
    ST_EDIT_MIN  = 2'd2,
    ST_EDIT_HOUR = 2'd3
  } state_t;

  localparam logic [2:0] DP_NONE = 3'b000;
  localparam logic [2:0] DP_SEC  = 3'b001;
  localparam logic [2:0] DP_MIN  = 3'b010;
  localparam logic [2:0] DP_HOUR = 3'b100;

  // Button indices into the debounced level / event vectors.
  localparam int BTN_MODE = 0;
  localparam int BTN_SEL  = 1;
  localparam int BTN_UP   = 2;
  localparam int BTN_DOWN = 3;

  // Debug view: current FSM state plus the four debounced levels.
  typedef struct packed {
    state_t     state;
    logic [3:0] level;
  } dbg_t;

  function automatic logic [2:0] state_to_dp(input state_t s);
    case (s)
      ST_EDIT_SEC:  return DP_SEC;
      ST_EDIT_MIN:  return DP_MIN;
      ST_EDIT_HOUR: return DP_HOUR;
      default:      return DP_NONE;
    endcase
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioning: 2-FF synchronizer, debouncer that adopts a new level
// only after DEBOUNCE_CYCLES consecutive differing samples, and a registered
// one-cycle press pulse the cycle after the debounced level rises.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 100_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic level,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level_q;
  logic [CW-1:0] cnt;

  // Two-stage synchronizer for the raw asynchronous button.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

  // Count consecutive samples that differ from the accepted level; any
  // agreeing sample restarts the count, so the counter never exceeds CNT_LAST.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (sync2 == level) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt   <= '0;
      level <= sync2;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Rising edge of the debounced level becomes a registered press pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q <= 1'b0;
      press   <= 1'b0;
    end else begin
      level_q <= level;
      press   <= level & ~level_q;
    end
  end

endmodule

// File: rtl/watch_cu.sv
// Watch control unit: debounces four buttons, runs the RUN/EDIT FSM, and
// issues single-cycle up/down adjust pulses with hold-to-repeat.
module watch_cu
  import watch_cu_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 100_000,
  parameter int REPEAT_DELAY    = 50_000_000,
  parameter int REPEAT_PERIOD   = 10_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_sel,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic [2:0] digit_pos,
  output logic       o_time_up,
  output logic       o_time_down,
  output logic       stop,
  output dbg_t       dbg
);

  localparam int DW = (REPEAT_DELAY  > 1) ? $clog2(REPEAT_DELAY)  : 1;
  localparam int PW = (REPEAT_PERIOD > 1) ? $clog2(REPEAT_PERIOD) : 1;
  localparam logic [DW-1:0] DLY_LAST = DW'(REPEAT_DELAY - 1);
  localparam logic [PW-1:0] PER_LAST = PW'(REPEAT_PERIOD - 1);

  logic [3:0]    btn_raw;
  logic [3:0]    lvl;
  logic [3:0]    evt;
  state_t        state;
  state_t        state_next;
  logic          edit;
  logic          chg;
  logic          both;
  logic          adj_up;
  logic          adj_dn;
  // Repeat engine, index 0 = up, 1 = down.
  logic [DW-1:0] dly_cnt [2];
  logic [PW-1:0] per_cnt [2];
  logic [1:0]    rep_phase;
  logic [1:0]    rep_run;
  logic [1:0]    fire;

  assign btn_raw = {btn_down, btn_up, btn_sel, btn_mode};

  for (genvar b = 0; b < 4; b++) begin : g_btn
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk   (clk),
      .rst   (rst),
      .btn   (btn_raw[b]),
      .level (lvl[b]),
      .press (evt[b])
    );
  end

  assign dbg.state = state;
  assign dbg.level = lvl;

  // Next state: mode toggles RUN/EDIT and beats sel; sel cycles edit fields.
  always_comb begin
    state_next = state;
    edit       = (state != ST_RUN);
    chg        = evt[BTN_MODE] | (evt[BTN_SEL] & edit);
    case (state)
      ST_RUN:       if (evt[BTN_MODE]) state_next = ST_EDIT_SEC;
      ST_EDIT_SEC:  if (evt[BTN_MODE]) state_next = ST_RUN;
                    else if (evt[BTN_SEL]) state_next = ST_EDIT_MIN;
      ST_EDIT_MIN:  if (evt[BTN_MODE]) state_next = ST_RUN;
                    else if (evt[BTN_SEL]) state_next = ST_EDIT_HOUR;
      ST_EDIT_HOUR: if (evt[BTN_MODE]) state_next = ST_RUN;
                    else if (evt[BTN_SEL]) state_next = ST_EDIT_SEC;
      default:      state_next = ST_RUN;
    endcase
  end

  // Repeat qualification and adjust-pulse selection. A press cycle, a state
  // change, leaving edit, release, or both directions held all clear the
  // engine, so repeat always restarts with a full delay.
  always_comb begin
    rep_run = '0;
    fire    = '0;
    both    = lvl[BTN_UP] & lvl[BTN_DOWN];
    for (int r = 0; r < 2; r++) begin
      rep_run[r] = edit & ~chg & ~both & lvl[BTN_UP + r] & ~evt[BTN_UP + r];
      fire[r]    = rep_run[r] & (rep_phase[r] ? (per_cnt[r] == PER_LAST)
                                              : (dly_cnt[r] == DLY_LAST));
    end
    adj_up = edit & ~chg & ~both & (evt[BTN_UP] | fire[0]);
    adj_dn = edit & ~chg & ~both & (evt[BTN_DOWN] | fire[1]) & ~adj_up;
  end

  // Repeat counters: delay phase, then fixed-period phase; reset on hit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < 2; r++) begin
        dly_cnt[r] <= '0;
        per_cnt[r] <= '0;
      end
      rep_phase <= '0;
    end else begin
      for (int r = 0; r < 2; r++) begin
        if (!rep_run[r]) begin
          dly_cnt[r]   <= '0;
          per_cnt[r]   <= '0;
          rep_phase[r] <= 1'b0;
        end else if (!rep_phase[r]) begin
          if (dly_cnt[r] == DLY_LAST) begin
            dly_cnt[r]   <= '0;
            rep_phase[r] <= 1'b1;
          end else begin
            dly_cnt[r] <= dly_cnt[r] + 1'b1;
          end
        end else if (per_cnt[r] == PER_LAST) begin
          per_cnt[r] <= '0;
        end else begin
          per_cnt[r] <= per_cnt[r] + 1'b1;
        end
      end
    end
  end

  // State register with digit_pos, stop and the adjust pulses registered alongside.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_RUN;
      digit_pos   <= DP_NONE;
      stop        <= 1'b0;
      o_time_up   <= 1'b0;
      o_time_down <= 1'b0;
    end else begin
      state       <= state_next;
      digit_pos   <= state_to_dp(state_next);
      stop        <= (state_next != ST_RUN);
      o_time_up   <= adj_up;
      o_time_down <= adj_dn;
    end
  end

endmodule

// File: tb/tb_watch_cu.sv
// Directed bench for watch_cu with short debounce/repeat parameters.
module tb_watch_cu;
  import watch_cu_pkg::*;

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_mode = 1'b0, btn_sel = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
  logic [2:0] digit_pos;
  logic o_time_up, o_time_down, stop;
  dbg_t dbg;

  always #5 clk = ~clk;

  watch_cu #(.DEBOUNCE_CYCLES(4), .REPEAT_DELAY(20), .REPEAT_PERIOD(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_mode    (btn_mode),
    .btn_sel     (btn_sel),
    .btn_up      (btn_up),
    .btn_down    (btn_down),
    .digit_pos   (digit_pos),
    .o_time_up   (o_time_up),
    .o_time_down (o_time_down),
    .stop        (stop),
    .dbg         (dbg)
  );

  // Scoreboard state
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int viol    = 0;
  int up_q[$];
  int dn_q[$];
  logic [31:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse recorder and output invariants, sampled on the falling edge.
  always @(negedge clk) begin
    if (o_time_up)   up_q.push_back(cyc);
    if (o_time_down) dn_q.push_back(cyc);
    if (o_time_up && o_time_down) viol++;
    if ((o_time_up || o_time_down) && digit_pos == DP_NONE) viol++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_btn(input int idx, input logic v);
    case (idx)
      BTN_MODE: btn_mode = v;
      BTN_SEL:  btn_sel  = v;
      BTN_UP:   btn_up   = v;
      default:  btn_down = v;
    endcase
  endtask

  task automatic press_btn(input int idx, input int hold);
    set_btn(idx, 1'b1);
    step(hold);
    set_btn(idx, 1'b0);
    step(12);
  endtask

  int c0;
  int got;

  initial begin
    // Reset state
    step(3);
    check("rst_dp",   32'(digit_pos),   32'(DP_NONE));
    check("rst_stop", 32'(stop),        0);
    check("rst_up",   32'(o_time_up),   0);
    check("rst_dn",   32'(o_time_down), 0);
    rst = 1'b0;
    step(3);

    // Mode press latency: 2 sync + 4 debounce + 1 pulse + 1 state register
    btn_mode = 1'b1;
    step(7);
    check("mode_lat_early", 32'(digit_pos), 32'(DP_NONE));
    step(1);
    check("mode_lat_dp",   32'(digit_pos), 32'(DP_SEC));
    check("mode_lat_stop", 32'(stop), 1);
    step(2);
    btn_mode = 1'b0;
    step(12);

    // Sel cycles the edit fields
    press_btn(BTN_SEL, 6);
    check("sel1", 32'(digit_pos), 32'(DP_MIN));
    press_btn(BTN_SEL, 6);
    check("sel2", 32'(digit_pos), 32'(DP_HOUR));
    press_btn(BTN_SEL, 6);
    check("sel3", 32'(digit_pos), 32'(DP_SEC));

    // Back to RUN; sel ignored there
    press_btn(BTN_MODE, 6);
    check("run_dp",   32'(digit_pos), 32'(DP_NONE));
    check("run_stop", 32'(stop), 0);
    press_btn(BTN_SEL, 6);
    check("run_sel", 32'(digit_pos), 32'(DP_NONE));

    // Enter EDIT_MIN; single down press
    press_btn(BTN_MODE, 6);
    press_btn(BTN_SEL, 6);
    check("edit_min_dp",    32'(digit_pos), 32'(DP_MIN));
    check("edit_min_state", 32'(dbg.state), 32'(ST_EDIT_MIN));
    up_q.delete(); dn_q.delete();
    press_btn(BTN_DOWN, 6);
    check("down_cnt", 32'(dn_q.size()), 1);
    check("down_up0", 32'(up_q.size()), 0);

    // Hold up 40 cycles: press pulse then repeat at +20, +25, +30, +35
    up_q.delete(); dn_q.delete();
    c0 = cyc;
    exp_q.push_back(32'(c0 + 8));
    exp_q.push_back(32'(c0 + 28));
    exp_q.push_back(32'(c0 + 33));
    exp_q.push_back(32'(c0 + 38));
    exp_q.push_back(32'(c0 + 43));
    btn_up = 1'b1;
    step(40);
    btn_up = 1'b0;
    step(14);
    check("rep_count", 32'(up_q.size()), 5);
    check("rep_dn0",   32'(dn_q.size()), 0);
    while (exp_q.size() > 0) begin
      got = (up_q.size() > 0) ? up_q.pop_front() : -1;
      check("rep_at", 32'(got), exp_q.pop_front());
    end

    // Glitches shorter than the debounce window never produce a pulse
    up_q.delete();
    for (int i = 0; i < 4; i++) begin
      btn_up = 1'b1; step(3);
      btn_up = 1'b0; step(3);
    end
    step(10);
    check("glitch", 32'(up_q.size()), 0);

    // Up and down held together: nothing
    up_q.delete(); dn_q.delete();
    btn_up = 1'b1; btn_down = 1'b1;
    step(30);
    btn_up = 1'b0; btn_down = 1'b0;
    step(12);
    check("both_up", 32'(up_q.size()), 0);
    check("both_dn", 32'(dn_q.size()), 0);

    // Clean up press in RUN: ignored
    press_btn(BTN_MODE, 6);
    check("run_again", 32'(digit_pos), 32'(DP_NONE));
    up_q.delete();
    press_btn(BTN_UP, 6);
    check("run_up", 32'(up_q.size()), 0);

    // Reset during repeat in EDIT_HOUR
    press_btn(BTN_MODE, 6);
    press_btn(BTN_SEL, 6);
    press_btn(BTN_SEL, 6);
    check("hour_dp", 32'(digit_pos), 32'(DP_HOUR));
    btn_up = 1'b1;
    step(33);
    check("pre_rst_pulse", 32'(o_time_up), 1);
    rst = 1'b1;
    btn_up = 1'b0;
    btn_mode = 1'b1;
    #1;
    check("rst_now_up",   32'(o_time_up), 0);
    check("rst_now_dp",   32'(digit_pos), 32'(DP_NONE));
    check("rst_now_stop", 32'(stop), 0);
    up_q.delete();
    step(3);
    // Mode held through reset release: one press after the full debounce
    rst = 1'b0;
    step(7);
    check("held_rst_early", 32'(digit_pos), 32'(DP_NONE));
    step(1);
    check("held_rst_dp", 32'(digit_pos), 32'(DP_SEC));
    btn_mode = 1'b0;
    step(12);
    check("rst_no_pulse", 32'(up_q.size()), 0);

    // Mode and up on the same cycle in EDIT_SEC: state change wins
    up_q.delete();
    btn_mode = 1'b1; btn_up = 1'b1;
    step(8);
    check("mode_up_dp", 32'(digit_pos), 32'(DP_NONE));
    btn_mode = 1'b0; btn_up = 1'b0;
    step(12);
    check("mode_up_nopulse", 32'(up_q.size()), 0);

    check("invariants", 32'(viol), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/watch_cu.md
WATCH_CU -- requirements
Module: watch_cu

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 100_000, meaning the stable-cycle count before a raw button level is accepted.
REQ-002 The block SHALL have parameter REPEAT_DELAY, default 50_000_000, meaning the held-cycle count before up/down auto-repeat starts.
REQ-003 The block SHALL have parameter REPEAT_PERIOD, default 10_000_000, meaning the cycle spacing between auto-repeat pulses.
REQ-004 The block SHALL have port clk, input, 1, meaning the system clock.
REQ-005 The block SHALL have port rst, input, 1, meaning reset; asynchronous, active-high.
REQ-006 The block SHALL have ports btn_mode, btn_sel, btn_up, btn_down, each input, 1, meaning a raw asynchronous active-high button.
REQ-007 The block SHALL have port digit_pos, output, 3, meaning the one-hot edit field (bit0 sec, bit1 min, bit2 hour), 000 when not editing.
REQ-008 The block SHALL have ports o_time_up and o_time_down, each output, 1, meaning a single-cycle adjust pulse.
REQ-009 The block SHALL have port stop, output, 1, meaning the freeze request for the 100 Hz tick generator, high while editing.

Function
REQ-010 Each button SHALL pass through a 2-FF synchronizer, then a debouncer that adopts the synchronized level only after it differs from the current debounced level for DEBOUNCE_CYCLES consecutive cycles; any glitch restarts the count.
REQ-011 A press event SHALL be a one-cycle pulse asserted the cycle after the debounced level rises; release SHALL generate no event.
REQ-012 The FSM SHALL have states RUN, EDIT_SEC, EDIT_MIN and EDIT_HOUR, with digit_pos driven as 000, 001, 010 and 100 respectively.
REQ-013 In RUN, a mode press SHALL move to EDIT_SEC; in any EDIT state, a mode press SHALL return to RUN.
REQ-014 In EDIT states, a sel press SHALL cycle SEC->MIN->HOUR->SEC; in RUN, sel SHALL be ignored.
REQ-015 stop SHALL be 1 in every EDIT state and 0 in RUN, registered together with the state.
REQ-016 o_time_up/o_time_down SHALL pulse for exactly one cycle, in the cycle after an up/down press event, only in EDIT states; in RUN, up/down SHALL be ignored.
REQ-017 Auto-repeat: once the debounced up (down) level has stayed high for REPEAT_DELAY cycles after its press pulse, a further pulse SHALL occur every REPEAT_PERIOD cycles until release or an exit from edit.
REQ-018 If up and down debounced levels are both high, no adjust pulses SHALL be produced, and repeat counters SHALL hold at zero.
REQ-019 If a mode or sel event coincides with an up/down event, the state change SHALL win and no adjust pulse SHALL be emitted in that cycle.
REQ-020 A mode and sel event in the same cycle SHALL be handled as mode only.
REQ-021 A state change SHALL clear the repeat counters, so repeat restarts with a full REPEAT_DELAY.
REQ-022 o_time_up and o_time_down SHALL never both be 1, and SHALL never be 1 while digit_pos is 000.
REQ-023 Counter widths SHALL be $clog2 of the respective parameter; counters SHALL saturate, not wrap, while waiting.

Reset
REQ-024 On rst SHALL immediately force: state RUN, digit_pos 000, stop 0, o_time_up 0, o_time_down 0, synchronizers and debounced levels 0, all counters 0.
REQ-025 Reset asserted mid-edit or mid-repeat SHALL abort with no further pulses; a button held through reset release SHALL produce one press event after DEBOUNCE_CYCLES.

Structure
REQ-026 A shared package SHALL hold the FSM state encoding and the digit_pos one-hot constants (DP_NONE, DP_SEC, DP_MIN, DP_HOUR).
REQ-027 Sub-module btn_debounce (synchronizer, debounce counter, rising-edge pulse, parameter DEBOUNCE_CYCLES) SHALL be instantiated four times; the FSM and repeat logic SHALL live in watch_cu.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=5)
REQ-028 Reset, then hold mode high 10 cycles -> digit_pos=001, stop=1; with no glitches, this SHALL occur exactly 2+4+1+1 cycles after the input rises.
REQ-029 In EDIT_SEC, press sel three times -> digit_pos 010, 100, 001; in RUN, sel SHALL leave digit_pos at 000.
REQ-030 In EDIT_MIN, hold up 40 cycles -> one o_time_up pulse at the press, then pulses every 5 cycles starting 20 cycles later, totalling 5; o_time_down stays 0.
REQ-031 Glitch up high for 3 cycles, repeated -> no pulse; in RUN, a clean up press -> no pulse; up and down held together -> no pulses.
REQ-032 Assert rst during repeat in EDIT_HOUR -> outputs 0 and digit_pos 000 in the same cycle; mode and up pressed on the same cycle in EDIT_SEC -> RUN with no o_time_up pulse.
